// File: rtl/sad_pkg.sv
// Shared constants for the SAD processor: image geometry, coordinate widths
// and the frame sequencer's state codes.
package sad_pkg;

  function automatic int calc_frame_bytes(input int w, input int h, input int ppb);
    return (w * h) / ppb;
  endfunction

  localparam int IMG_W        = 640;
  localparam int IMG_H        = 480;
  localparam int PIX_PER_BYTE = 8;
  localparam int FRAME_BYTES  = calc_frame_bytes(IMG_W, IMG_H, PIX_PER_BYTE);

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

endpackage

// File: rtl/sad_rise_detect.sv
// Registered rising-edge detector: one-cycle strobe on the first cycle a level
// is seen high, no matter how long it stays high.
module sad_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/sad_frame_sequencer.sv
// Frame sequencer: loads the received image into the frame buffer, kicks off
// the SAD search and holds the best-match coordinate until it has been sent.
module sad_frame_sequencer
  import sad_pkg::X_W, sad_pkg::Y_W;
#(
  parameter int IMG_W        = sad_pkg::IMG_W,
  parameter int IMG_H        = sad_pkg::IMG_H,
  parameter int PIX_PER_BYTE = sad_pkg::PIX_PER_BYTE,
  parameter int ADDR_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              UARTstart,
  input  logic              UARTready,
  input  logic [7:0]        data_in,
  input  logic              UARTsendComplete,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              sad_start,
  input  logic              sad_done,
  input  logic [X_W-1:0]    sad_x,
  input  logic [Y_W-1:0]    sad_y,
  output logic              valid_out,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic              busy
);

  import sad_pkg::ST_IDLE;
  import sad_pkg::ST_LOAD;
  import sad_pkg::ST_SEARCH;
  import sad_pkg::ST_REPORT;
  import sad_pkg::calc_frame_bytes;

  localparam int FRAME_BYTES = calc_frame_bytes(IMG_W, IMG_H, PIX_PER_BYTE);
  // One spare bit so the counter can sit at FRAME_BYTES without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BYTES);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             byte_rise;

  sad_rise_detect u_rise (
    .clock (clock),
    .reset (reset),
    .level (UARTready),
    .rise  (byte_rise)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      sad_start <= 1'b0;
      valid_out <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      wr_en     <= 1'b0;
      sad_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (UARTstart) begin
            state <= ST_LOAD;
            count <= '0;
          end
        end
        // A start strobe restarts the frame and swallows any byte arriving with it.
        ST_LOAD: begin
          if (UARTstart) begin
            count <= '0;
          end else if (count == FULL_CNT) begin
            state     <= ST_SEARCH;
            sad_start <= 1'b1;
          end else if (byte_rise) begin
            wr_en   <= 1'b1;
            wr_addr <= count[ADDR_W-1:0];
            wr_data <= data_in;
            count   <= count + CNT_W'(1);
          end
        end
        ST_SEARCH: begin
          if (sad_done) begin
            x_out     <= sad_x;
            y_out     <= sad_y;
            valid_out <= 1'b1;
            state     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (UARTsendComplete) begin
            valid_out <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
